// File: rtl/mig_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mig_cmd_arbiter
// Description : Round-robin arbiter and sequencer for the single MIG command
//               port (write and read command channels) shared by NREQ
//               requesters. One whole transaction is granted at a time:
//               command handshake, then beat counting on the 512-bit data
//               bus until the message is complete.
//
// Ports       : ui_clk, aresetn        clock, async active-low reset
//               req_valid/write/...    per-requester request (sliced buses)
//               req_ready, req_done    one-cycle accept / completion pulses
//               grant                  one-hot owner, accept through DONE
//               busy                   arbiter not idle
//               write*/read*           MIG write / read command channels
//               wvalid, rvalid         MIG data beat strobes
//               timeout_err            sticky beat-gap error
//
// Options     : define MIG_ARB_TIMEOUT_EN to abort a transfer whose beats
//               stall for TIMEOUT cycles (timeout_err is tied 0 otherwise).
//
// Revision    : 1.0  initial release
// ============================================================================
module mig_cmd_arbiter #(
    parameter int NREQ       = 4,
    parameter int BEAT_SHIFT = 5,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 ui_clk,
    input  logic                 aresetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [32*NREQ-1:0]   req_address,
    input  logic [16*NREQ-1:0]   req_size,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 writevalid,
    output logic [31:0]          writeaddress,
    output logic [15:0]          writemessagesize,
    input  logic                 writeready,
    output logic                 readvalid,
    output logic [31:0]          readaddress,
    output logic [15:0]          readmessagesize,
    input  logic                 readready,
    input  logic                 wvalid,
    input  logic                 rvalid,
    output logic                 timeout_err
);

    localparam int          c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [16:0] c_ROUND = 17'((1 << BEAT_SHIFT) - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_XFER  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_ready;
    logic [NREQ-1:0]     r_done;
    logic                r_busy;
    logic                r_write;
    logic [31:0]         r_addr;
    logic [15:0]         r_size;
    logic [11:0]         r_exp;
    logic [11:0]         r_beats;
    logic                r_writevalid;
    logic [31:0]         r_writeaddress;
    logic [15:0]         r_writemessagesize;
    logic                r_readvalid;
    logic [31:0]         r_readaddress;
    logic [15:0]         r_readmessagesize;
    logic                r_timeout_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic                w_found;
    logic [c_PTR_W-1:0]  w_win;
    logic [c_PTR_W-1:0]  w_idx;
    logic [NREQ-1:0]     w_win_oh;
    logic                w_sel_write;
    logic [31:0]         w_sel_addr;
    logic [15:0]         w_sel_size;
    logic [11:0]         w_sel_beats;
    logic                w_beat;
    logic                w_last;
    logic                w_cmd_ready;
    logic                w_timeout;
    logic [1:0]          w_next_state;

    // Search starts just above the last winner and wraps, so the most
    // recently served requester has the lowest priority next time.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = c_PTR_W'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Constant-index mux of the winner's request fields.
    always_comb begin
        w_win_oh    = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_size  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == c_PTR_W'(k)) begin
                w_win_oh[k] = 1'b1;
                w_sel_write = req_write[k];
                w_sel_addr  = req_address[32*k +: 32];
                w_sel_size  = req_size[16*k +: 16];
            end
        end
    end

    // Round the element count up to whole beats.
    assign w_sel_beats = 12'(({1'b0, w_sel_size} + c_ROUND) >> BEAT_SHIFT);

    // Only the beat strobe matching the granted direction counts.
    assign w_beat      = r_write ? wvalid : rvalid;
    assign w_last      = (r_state == c_XFER) && w_beat && ((r_beats + 12'd1) == r_exp);
    assign w_cmd_ready = r_write ? writeready : readready;

`ifdef MIG_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    // Cycles elapsed since the command pulse or the most recent counted beat.
    logic [c_TO_W-1:0] r_idle;

    assign w_timeout = (r_state == c_XFER) && !w_beat &&
                       ((r_idle + c_TO_W'(1)) == c_TO_W'(TIMEOUT));

    always_ff @(posedge ui_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_idle <= '0;
        end else if (r_state != c_XFER) begin
            r_idle <= '0;
        end else if (w_beat) begin
            r_idle <= c_TO_W'(1);
        end else begin
            r_idle <= r_idle + c_TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_next_state = c_ISSUE;
            c_ISSUE: begin
                if (r_size == 16'd0)  w_next_state = c_DONE;
                else if (w_cmd_ready) w_next_state = c_XFER;
            end
            c_XFER:  if (w_last || w_timeout) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state            <= c_IDLE;
            r_ptr              <= c_PTR_W'(NREQ - 1);
            r_grant            <= '0;
            r_ready            <= '0;
            r_done             <= '0;
            r_busy             <= 1'b0;
            r_write            <= 1'b0;
            r_addr             <= '0;
            r_size             <= '0;
            r_exp              <= '0;
            r_beats            <= '0;
            r_writevalid       <= 1'b0;
            r_writeaddress     <= '0;
            r_writemessagesize <= '0;
            r_readvalid        <= 1'b0;
            r_readaddress      <= '0;
            r_readmessagesize  <= '0;
            r_timeout_err      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != c_IDLE);
            r_ready      <= '0;
            r_done       <= '0;
            r_writevalid <= 1'b0;
            r_readvalid  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_ready <= w_win_oh;
                        r_grant <= w_win_oh;
                        r_ptr   <= w_win;
                        r_write <= w_sel_write;
                        r_addr  <= w_sel_addr;
                        r_size  <= w_sel_size;
                        r_exp   <= w_sel_beats;
                        r_beats <= '0;
                    end
                end
                c_ISSUE: begin
                    if (r_size == 16'd0) begin
                        r_done <= r_grant;
                    end else if (r_write && writeready) begin
                        r_writevalid       <= 1'b1;
                        r_writeaddress     <= r_addr;
                        r_writemessagesize <= r_size;
                    end else if (!r_write && readready) begin
                        r_readvalid       <= 1'b1;
                        r_readaddress     <= r_addr;
                        r_readmessagesize <= r_size;
                    end
                end
                c_XFER: begin
                    if (w_beat) r_beats <= r_beats + 12'd1;
                    if (w_last || w_timeout) r_done <= r_grant;
                    if (w_timeout) r_timeout_err <= 1'b1;
                end
                c_DONE: begin
                    r_grant <= '0;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign req_ready        = r_ready;
    assign req_done         = r_done;
    assign grant            = r_grant;
    assign busy             = r_busy;
    assign writevalid       = r_writevalid;
    assign writeaddress     = r_writeaddress;
    assign writemessagesize = r_writemessagesize;
    assign readvalid        = r_readvalid;
    assign readaddress      = r_readaddress;
    assign readmessagesize  = r_readmessagesize;
    assign timeout_err      = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mig_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mig_cmd_arbiter
// Description : Self-checking bench for mig_cmd_arbiter. Expected transactions
//               are queued when requests are driven and popped when the DUT
//               accepts them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mig_cmd_arbiter;

    localparam int NREQ       = 4;
    localparam int BEAT_SHIFT = 5;
`ifdef MIG_ARB_TIMEOUT_EN
    localparam int TIMEOUT    = 16;
`else
    localparam int TIMEOUT    = 1024;
`endif

    logic                ui_clk = 1'b0;
    logic                aresetn = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_write = '0;
    logic [32*NREQ-1:0]  req_address = '0;
    logic [16*NREQ-1:0]  req_size = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_done;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                writevalid;
    logic [31:0]         writeaddress;
    logic [15:0]         writemessagesize;
    logic                writeready = 1'b1;
    logic                readvalid;
    logic [31:0]         readaddress;
    logic [15:0]         readmessagesize;
    logic                readready = 1'b1;
    logic                wvalid = 1'b0;
    logic                rvalid = 1'b0;
    logic                timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          owner;
        logic        wr;
        logic [31:0] addr;
        logic [15:0] size;
    } txn_t;

    txn_t sb[$];

    mig_cmd_arbiter #(
        .NREQ       (NREQ),
        .BEAT_SHIFT (BEAT_SHIFT),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .ui_clk           (ui_clk),
        .aresetn          (aresetn),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_size         (req_size),
        .req_ready        (req_ready),
        .req_done         (req_done),
        .grant            (grant),
        .busy             (busy),
        .writevalid       (writevalid),
        .writeaddress     (writeaddress),
        .writemessagesize (writemessagesize),
        .writeready       (writeready),
        .readvalid        (readvalid),
        .readaddress      (readaddress),
        .readmessagesize  (readmessagesize),
        .readready        (readready),
        .wvalid           (wvalid),
        .rvalid           (rvalid),
        .timeout_err      (timeout_err)
    );

    always #5 ui_clk = ~ui_clk;

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic tick();
        @(negedge ui_clk);
    endtask

    task automatic set_req(input int k, input logic wr, input logic [31:0] a, input logic [15:0] s);
        req_valid[k]          = 1'b1;
        req_write[k]          = wr;
        req_address[k*32 +: 32] = a;
        req_size[k*16 +: 16]    = s;
    endtask

    function automatic txn_t mk(input int k, input logic wr, input logic [31:0] a, input logic [15:0] s);
        txn_t t;
        t.owner = k; t.wr = wr; t.addr = a; t.size = s;
        return t;
    endfunction

    function automatic int beats_of(input logic [15:0] s);
        return (int'(s) + (1 << BEAT_SHIFT) - 1) >> BEAT_SHIFT;
    endfunction

    task automatic wait_ready(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cycles++;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_beats(input logic wr, input int n, output int early);
        early = 0;
        for (int i = 0; i < n; i++) begin
            if (wr) wvalid = 1'b1; else rvalid = 1'b1;
            tick();
            if (i < n - 1 && req_done != '0) early++;
        end
        wvalid = 1'b0;
        rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        total++;
        if ({req_ready, req_done, grant, busy, writevalid, writeaddress, writemessagesize,
             readvalid, readaddress, readmessagesize, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b done=%b grant=%b busy=%b wv=%b rv=%b err=%b, expected all 0",
                     req_ready, req_done, grant, busy, writevalid, readvalid, timeout_err);
        end
        aresetn = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b grant=%b, expected 0/0", busy, grant);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int cyc; int early; txn_t e; logic [NREQ-1:0] oh;
        for (int k = 0; k < NREQ; k++) set_req(k, (k % 2) == 0, 32'h1000 * (k + 1), 16'd32);
        for (int t = 0; t < 5; t++) begin
            int k;
            k = t % NREQ;
            sb.push_back(mk(k, (k % 2) == 0, 32'h1000 * (k + 1), 16'd32));
        end
        for (int t = 0; t < 5; t++) begin
            wait_ready(ok, cyc);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rr_ready_timeout: no req_ready within 50 cycles (txn %0d)", t);
                break;
            end
            e = sb.pop_front();
            oh = '0; oh[e.owner] = 1'b1;
            total++;
            if (req_ready !== oh || grant !== oh || busy !== 1'b1) begin
                bad++;
                $display("FAIL rr_grant: txn %0d got ready=%b grant=%b busy=%b, expected %b/%b/1",
                         t, req_ready, grant, busy, oh, oh);
            end
            if (t > 0) begin
                total++;
                if (cyc != 1) begin
                    bad++;
                    $display("FAIL rr_overhead: txn %0d accepted after %0d cycles, expected 1", t, cyc);
                end
            end
            if (t == 4) req_valid = '0;
            tick();
            total++;
            if (e.wr ? (writevalid !== 1'b1 || writeaddress !== e.addr || writemessagesize !== e.size || readvalid !== 1'b0)
                     : (readvalid !== 1'b1 || readaddress !== e.addr || readmessagesize !== e.size || writevalid !== 1'b0)) begin
                bad++;
                $display("FAIL rr_cmd: txn %0d got wv=%b wa=%h rv=%b ra=%h, expected dir=%b addr=%h size=%0d",
                         t, writevalid, writeaddress, readvalid, readaddress, e.wr, e.addr, e.size);
            end
            do_beats(e.wr, beats_of(e.size), early);
            total++;
            if (req_done !== oh || early != 0) begin
                bad++;
                $display("FAIL rr_done: txn %0d got done=%b early=%0d, expected %b/0", t, req_done, early, oh);
            end
            tick();
            total++;
            if (grant !== '0 || req_done !== '0) begin
                bad++;
                $display("FAIL rr_release: txn %0d got grant=%b done=%b, expected 0/0", t, grant, req_done);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_single_write();
        bit ok; int cyc; int early; txn_t e;
        set_req(0, 1'b1, 32'h0, 16'd1024);
        sb.push_back(mk(0, 1'b1, 32'h0, 16'd1024));
        wait_ready(ok, cyc);
        total++;
        if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL wr_ready_latency: got ok=%0d cycles=%0d, expected 1/1", ok, cyc);
        end
        e = sb.pop_front();
        total++;
        if (req_ready !== 4'b0001 || grant !== 4'b0001 || writevalid !== 1'b0) begin
            bad++;
            $display("FAIL wr_accept: got ready=%b grant=%b wv=%b, expected 0001/0001/0", req_ready, grant, writevalid);
        end
        req_valid = '0;
        tick();
        total++;
        if (writevalid !== 1'b1 || writeaddress !== e.addr || writemessagesize !== e.size || req_ready !== '0) begin
            bad++;
            $display("FAIL wr_cmd: got wv=%b addr=%h size=%0d ready=%b, expected 1/%h/%0d/0",
                     writevalid, writeaddress, writemessagesize, req_ready, e.addr, e.size);
        end
        do_beats(1'b1, beats_of(e.size), early);
        total++;
        if (req_done !== 4'b0001 || early != 0 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL wr_done: got done=%b early=%0d grant=%b, expected 0001/0/0001", req_done, early, grant);
        end
        tick();
        total++;
        if (grant !== '0 || busy !== 1'b0 || writevalid !== 1'b0 || writeaddress !== e.addr) begin
            bad++;
            $display("FAIL wr_idle: got grant=%b busy=%b wv=%b waddr=%h, expected 0/0/0/%h",
                     grant, busy, writevalid, writeaddress, e.addr);
        end
    endtask

    task automatic test_read_size33();
        bit ok; int cyc; int early; txn_t e;
        set_req(2, 1'b0, 32'h1200, 16'd33);
        sb.push_back(mk(2, 1'b0, 32'h1200, 16'd33));
        wait_ready(ok, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL rd_accept: got ok=%0d ready=%b, expected 1/0100", ok, req_ready);
        end
        req_valid = '0;
        tick();
        total++;
        if (readvalid !== 1'b1 || readaddress !== e.addr || readmessagesize !== e.size || writevalid !== 1'b0) begin
            bad++;
            $display("FAIL rd_cmd: got rv=%b addr=%h size=%0d wv=%b, expected 1/%h/%0d/0",
                     readvalid, readaddress, readmessagesize, writevalid, e.addr, e.size);
        end
        do_beats(1'b0, beats_of(e.size), early);
        total++;
        if (req_done !== 4'b0100 || early != 0) begin
            bad++;
            $display("FAIL rd_done_2beats: got done=%b early=%0d, expected 0100/0", req_done, early);
        end
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        total++;
        if (req_done !== '0 || grant !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_extra_beat: got done=%b grant=%b busy=%b, expected 0/0/0", req_done, grant, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; int early; int pulses; txn_t e;
        readready = 1'b0;
        set_req(3, 1'b0, 32'h4000, 16'd64);
        sb.push_back(mk(3, 1'b0, 32'h4000, 16'd64));
        wait_ready(ok, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL bp_accept: got ok=%0d ready=%b, expected 1/1000", ok, req_ready);
        end
        req_valid = '0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (readvalid || writevalid) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL bp_no_cmd: got %0d command pulses while readready=0, expected 0", pulses);
        end
        readready = 1'b1;
        tick();
        total++;
        if (readvalid !== 1'b1 || readaddress !== e.addr || readmessagesize !== e.size) begin
            bad++;
            $display("FAIL bp_cmd: got rv=%b addr=%h size=%0d, expected 1/%h/%0d",
                     readvalid, readaddress, readmessagesize, e.addr, e.size);
        end
        wvalid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (req_done != '0) pulses++;
        end
        total++;
        if (pulses != 0 || grant !== 4'b1000) begin
            bad++;
            $display("FAIL bp_wvalid_noise: got done pulses=%0d grant=%b, expected 0/1000", pulses, grant);
        end
        do_beats(1'b0, beats_of(e.size), early);
        wvalid = 1'b0;
        total++;
        if (req_done !== 4'b1000 || early != 0) begin
            bad++;
            $display("FAIL bp_done: got done=%b early=%0d, expected 1000/0", req_done, early);
        end
        tick();
    endtask

    task automatic test_size0_and_reset();
        bit ok; int cyc; int early; int cmds; txn_t e;
        set_req(1, 1'b1, 32'h80, 16'd0);
        sb.push_back(mk(1, 1'b1, 32'h80, 16'd0));
        wait_ready(ok, cyc);
        e = sb.pop_front();
        cmds = (writevalid || readvalid) ? 1 : 0;
        total++;
        if (!ok || req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL sz0_accept: got ok=%0d ready=%b, expected 1/0010", ok, req_ready);
        end
        req_valid = '0;
        tick();
        if (writevalid || readvalid) cmds++;
        total++;
        if (req_done !== 4'b0010 || cmds != 0 || grant !== 4'b0010) begin
            bad++;
            $display("FAIL sz0_done: got done=%b cmds=%0d grant=%b, expected 0010/0/0010", req_done, cmds, grant);
        end
        tick();
        if (writevalid || readvalid) cmds++;
        total++;
        if (grant !== '0 || cmds != 0) begin
            bad++;
            $display("FAIL sz0_release: got grant=%b cmds=%0d, expected 0/0", grant, cmds);
        end

        // Reset in the middle of a long write transfer.
        set_req(2, 1'b1, 32'h8000, 16'd1024);
        wait_ready(ok, cyc);
        req_valid = '0;
        tick();
        do_beats(1'b1, 3, early);
        aresetn = 1'b0;
        #1;
        total++;
        if ({req_ready, req_done, grant, busy, writevalid, writeaddress, writemessagesize,
             readvalid, readaddress, readmessagesize, timeout_err} !== '0) begin
            bad++;
            $display("FAIL async_reset: got ready=%b done=%b grant=%b busy=%b wa=%h, expected all 0",
                     req_ready, req_done, grant, busy, writeaddress);
        end
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 32'h100 * k, 16'd32);
        sb.push_back(mk(0, 1'b1, 32'h0, 16'd32));
        wait_ready(ok, cyc);
        e = sb.pop_front();
        total++;
        if (!ok || req_ready !== 4'b0001 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset_winner: got ready=%b grant=%b, expected 0001/0001", req_ready, grant);
        end
        req_valid = '0;
        tick();
        do_beats(1'b1, beats_of(e.size), early);
        total++;
        if (req_done !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset_done: got done=%b, expected 0001", req_done);
        end
        tick();
    endtask

`ifdef MIG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int cyc; int early; int gap; bit seen;
        set_req(0, 1'b1, 32'h2000, 16'd1024);
        wait_ready(ok, cyc);
        req_valid = '0;
        tick();
        do_beats(1'b1, 5, early);
        // Cycle M+1 is visible now; req_done must show in cycle M+16.
        gap = 1;
        seen = (req_done != '0);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            gap++;
            seen = (req_done != '0);
        end
        total++;
        if (!seen || gap != 16 || req_done !== 4'b0001 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_done: got seen=%0d gap=%0d done=%b err=%b, expected 1/16/0001/1",
                     seen, gap, req_done, timeout_err);
        end
        tick();
        total++;
        if (grant !== '0 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got grant=%b err=%b, expected 0/1", grant, timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_read_size33();
        test_backpressure();
        test_size0_and_reset();
`ifdef MIG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
